// File: rtl/core_pkg.sv
// Purpose: shared types, widths and funct3 encodings for the memory-access stage.
// Contents: XLEN/REG_ADDR_W, lsu_state_t FSM encoding, F3_* access codes and
//           the access_illegal() legality check used by the stage top.
package core_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Unsupported size encodings, unsigned stores, and misaligned halfword or
    // word accesses are all refused before any request reaches memory.
    function automatic logic access_illegal(input logic [2:0] f3,
                                            input logic       is_store,
                                            input logic [1:0] addr_lo);
        logic ill;
        ill = (f3[1:0] == 2'b11) || (f3 == 3'b110) || (is_store && f3[2]);
        if ((f3[1:0] == F3_H[1:0]) && addr_lo[0])
            ill = 1'b1;
        if ((f3[1:0] == F3_W[1:0]) && (addr_lo != 2'b00))
            ill = 1'b1;
        return ill;
    endfunction

endpackage

// File: rtl/stage_mem_access_load_align.sv
// Purpose: pick the addressed byte/halfword out of a load word and extend it.
// Latency: purely combinational.
// Ports: rdata (load word), addr (byte offset), funct3 (size/sign) -> result.
module load_align
    import core_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addr,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        signed_ld;

    always_comb begin
        byte_sel  = rdata[7:0];
        half_sel  = rdata[15:0];
        result    = rdata;
        // funct3[2] distinguishes the unsigned (BU/HU) variants
        signed_ld = ~funct3[2];

        case (addr)
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            2'd3:    byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase

        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

        case (funct3[1:0])
            2'b00:   result = {{(XLEN-8){signed_ld & byte_sel[7]}}, byte_sel};
            2'b01:   result = {{(XLEN-16){signed_ld & half_sel[15]}}, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/stage_mem_access.sv
// Purpose: RV32 memory-access stage; issues loads/stores on a req/gnt/rvalid
//          port, aligns load data and registers the writeback bundle.
// Latency: non-mem ops 1 cycle; store 2 edges, load 3 edges with immediate gnt/rvalid.
// Backpressure: stall is held combinationally while a legal access is
//          outstanding and drops in the completing cycle.
// Ports: in_* from the previous stage, dmem_* data-memory port, wb_* to
//        writeback, mem_exc/mem_exc_addr for misaligned or illegal accesses.
module stage_mem_access
    import core_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  in_valid,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic [XLEN-1:0]       in_alu_result,
    input  logic [XLEN-1:0]       in_store_data,
    input  logic                  in_mem_read,
    input  logic                  in_mem_write,
    input  logic [2:0]            in_funct3,
    input  logic                  in_wr_enable,

    output logic                  stall,

    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [XLEN-1:0]       dmem_addr,
    output logic [3:0]            dmem_be,
    output logic [XLEN-1:0]       dmem_wdata,
    input  logic                  dmem_gnt,
    input  logic                  dmem_rvalid,
    input  logic [XLEN-1:0]       dmem_rdata,

    output logic                  wb_valid,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [XLEN-1:0]       wb_data,
    output logic                  wb_wr_enable,
    output logic                  mem_exc,
    output logic [XLEN-1:0]       mem_exc_addr
);

    lsu_state_t state, state_nxt;

    logic            memop;
    logic            is_load;
    logic            is_store;
    logic            illegal;
    logic            legal_memop;
    logic            done;
    logic [3:0]      be_raw;
    logic [XLEN-1:0] wdata_raw;
    logic [XLEN-1:0] load_data;

    // A request with both read and write set is treated as a load.
    assign memop       = in_valid & (in_mem_read | in_mem_write);
    assign is_load     = in_mem_read;
    assign is_store    = in_mem_write & ~in_mem_read;
    assign illegal     = memop & access_illegal(in_funct3, is_store, in_alu_result[1:0]);
    assign legal_memop = memop & ~illegal;

    // Stores finish on grant, loads on returned data.
    assign done  = ((state == REQ) & dmem_gnt & is_store) |
                   ((state == WAIT) & dmem_rvalid);
    assign stall = legal_memop & ~done;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (legal_memop) state_nxt = REQ;
            REQ:  if (dmem_gnt)    state_nxt = is_load ? WAIT : IDLE;
            WAIT: if (dmem_rvalid) state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    // Lane steering for stores; byte/half data is replicated so the memory
    // only needs the byte enables to pick the right lanes.
    always_comb begin
        be_raw    = 4'b1111;
        wdata_raw = in_store_data;
        case (in_funct3[1:0])
            2'b00: begin
                be_raw    = 4'b0001 << in_alu_result[1:0];
                wdata_raw = {4{in_store_data[7:0]}};
            end
            2'b01: begin
                be_raw    = 4'b0011 << in_alu_result[1:0];
                wdata_raw = {2{in_store_data[15:0]}};
            end
            default: begin
                be_raw    = 4'b1111;
                wdata_raw = in_store_data;
            end
        endcase
    end

    // Port fields are forced to zero outside REQ so nothing leaks while idle.
    assign dmem_req   = (state == REQ);
    assign dmem_we    = dmem_req & is_store;
    assign dmem_addr  = dmem_req ? {in_alu_result[XLEN-1:2], 2'b00} : '0;
    assign dmem_be    = dmem_req ? be_raw : 4'b0000;
    assign dmem_wdata = dmem_req ? wdata_raw : '0;

    load_align u_load_align (
        .rdata  (dmem_rdata),
        .addr   (in_alu_result[1:0]),
        .funct3 (in_funct3),
        .result (load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            wb_wr_enable <= 1'b0;
            mem_exc      <= 1'b0;
            mem_exc_addr <= '0;
        end else begin
            state        <= state_nxt;
            wb_valid     <= 1'b0;
            mem_exc      <= 1'b0;
            mem_exc_addr <= '0;

            if (illegal) begin
                // Faulting op still retires so the pipeline keeps moving,
                // but it never writes the register file.
                wb_valid     <= 1'b1;
                wb_rd        <= in_rd;
                wb_data      <= in_alu_result;
                wb_wr_enable <= 1'b0;
                mem_exc      <= 1'b1;
                mem_exc_addr <= in_alu_result;
            end else if (done) begin
                wb_valid     <= 1'b1;
                wb_rd        <= in_rd;
                wb_data      <= is_load ? load_data : in_alu_result;
                wb_wr_enable <= is_load & in_wr_enable;
            end else if (!memop) begin
                wb_valid     <= in_valid;
                wb_rd        <= in_rd;
                wb_data      <= in_alu_result;
                wb_wr_enable <= in_wr_enable & in_valid;
            end
        end
    end

endmodule

// File: tb/tb_stage_mem_access.sv
module tb_stage_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [4:0]  in_rd;
    logic [31:0] in_alu_result;
    logic [31:0] in_store_data;
    logic        in_mem_read;
    logic        in_mem_write;
    logic [2:0]  in_funct3;
    logic        in_wr_enable;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_wr_enable;
    logic        mem_exc;
    logic [31:0] mem_exc_addr;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        chk;
        logic        wr_en;
        logic        exc;
        logic [31:0] exc_addr;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    stage_mem_access dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_rd(in_rd), .in_alu_result(in_alu_result),
        .in_store_data(in_store_data), .in_mem_read(in_mem_read),
        .in_mem_write(in_mem_write), .in_funct3(in_funct3), .in_wr_enable(in_wr_enable),
        .stall(stall),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_wr_enable(wb_wr_enable), .mem_exc(mem_exc), .mem_exc_addr(mem_exc_addr)
    );

    // Writeback scoreboard: every wb pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (wb_valid === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL wb_unexpected: got rd=%0d data=%h we=%b exc=%b, none expected",
                         wb_rd, wb_data, wb_wr_enable, mem_exc);
            end else begin
                e = sb.pop_front();
                if ((e.chk && (wb_rd !== e.rd || wb_data !== e.data)) ||
                    wb_wr_enable !== e.wr_en || mem_exc !== e.exc ||
                    (e.exc && mem_exc_addr !== e.exc_addr)) begin
                    bad++;
                    $display("FAIL wb_bundle: got rd=%0d data=%h we=%b exc=%b eaddr=%h, want rd=%0d data=%h we=%b exc=%b eaddr=%h",
                             wb_rd, wb_data, wb_wr_enable, mem_exc, mem_exc_addr,
                             e.rd, e.data, e.wr_en, e.exc, e.exc_addr);
                end
            end
        end else if (mem_exc === 1'b1) begin
            total++;
            bad++;
            $display("FAIL exc_without_wb: mem_exc=1 while wb_valid=0");
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        in_valid = 0; in_rd = 0; in_alu_result = 0; in_store_data = 0;
        in_mem_read = 0; in_mem_write = 0; in_funct3 = 0; in_wr_enable = 0;
    endtask

    task automatic push(input logic [4:0] rd, input logic [31:0] data, input logic chk,
                        input logic we, input logic exc, input logic [31:0] eaddr);
        exp_t e;
        e.rd = rd; e.data = data; e.chk = chk; e.wr_en = we; e.exc = exc; e.exc_addr = eaddr;
        sb.push_back(e);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 10 && sb.size() != 0; i++) begin
            @(negedge clk); #1;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain_%s: %0d writebacks outstanding, want 0", name, sb.size());
            sb.delete();
        end
    endtask

    // Issue one legal memory op, answer the port with a gnt delay, check the
    // request fields, stall cycle count and request hold length.
    task automatic run_mem(input string name, input logic [31:0] addr, input logic [2:0] f3,
                           input logic st, input logic [31:0] sdata, input logic [4:0] rd,
                           input logic [31:0] rdata, input int gnt_delay,
                           input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                           input logic [31:0] exp_data, input int exp_stalls);
        int   stalls = 0;
        int   reqs = 0;
        logic waiting = 0;
        logic go_wait = 0;
        logic finished = 0;
        logic checked = 0;
        push(rd, exp_data, !st, !st, 1'b0, 32'h0);
        @(posedge clk); #1;
        in_valid = 1; in_rd = rd; in_alu_result = addr; in_store_data = sdata;
        in_mem_read = !st; in_mem_write = st; in_funct3 = f3; in_wr_enable = !st;
        for (int c = 0; c < 40 && !finished; c++) begin
            @(negedge clk);
            dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
            if (dmem_req === 1'b1) begin
                if (!checked) begin
                    checked = 1;
                    total++;
                    if (dmem_addr !== {addr[31:2], 2'b00} || dmem_be !== exp_be ||
                        dmem_we !== st || (st && dmem_wdata !== exp_wdata)) begin
                        bad++;
                        $display("FAIL req_%s: got addr=%h be=%b we=%b wdata=%h, want addr=%h be=%b we=%b wdata=%h",
                                 name, dmem_addr, dmem_be, dmem_we, dmem_wdata,
                                 {addr[31:2], 2'b00}, exp_be, st, exp_wdata);
                    end
                end
                if (reqs >= gnt_delay) begin
                    dmem_gnt = 1;
                    if (st) finished = 1; else go_wait = 1;
                end
                reqs++;
            end else if (waiting) begin
                dmem_rvalid = 1; dmem_rdata = rdata; finished = 1;
            end
            #1;
            if (stall === 1'b1) stalls++;
            @(posedge clk); #1;
            if (go_wait) waiting = 1;
            go_wait = 0;
        end
        idle_inputs();
        dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
        total++;
        if (!finished) begin
            bad++;
            $display("FAIL timeout_%s: access never completed", name);
        end
        total++;
        if (stalls != exp_stalls) begin
            bad++;
            $display("FAIL stall_len_%s: got %0d cycles, want %0d", name, stalls, exp_stalls);
        end
        total++;
        if (reqs != gnt_delay + 1) begin
            bad++;
            $display("FAIL req_hold_%s: got %0d cycles, want %0d", name, reqs, gnt_delay + 1);
        end
        drain(name);
    endtask

    task automatic test_reset();
        idle_inputs();
        dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
        rst = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({stall, dmem_req, dmem_we, dmem_be, wb_valid, wb_wr_enable, mem_exc} !== 10'b0 ||
            dmem_addr !== 0 || dmem_wdata !== 0 || wb_rd !== 0 || wb_data !== 0 || mem_exc_addr !== 0) begin
            bad++;
            $display("FAIL reset_outputs: got stall=%b req=%b wbv=%b wb_data=%h exc=%b, want all 0",
                     stall, dmem_req, wb_valid, wb_data, mem_exc);
        end
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic test_load_word();
        run_mem("lw", 32'h100, 3'b010, 0, 0, 5'd3, 32'hDEADBEEF, 0, 4'b1111, 0, 32'hDEADBEEF, 2);
    endtask

    task automatic test_load_sub();
        logic [31:0] addrs [6] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100, 32'h100};
        logic [2:0]  f3s   [6] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b001, 3'b000};
        logic [3:0]  bes   [6] = '{4'b1000, 4'b1000, 4'b1100, 4'b1100, 4'b0011, 4'b0001};
        logic [31:0] exps  [6] = '{32'hFFFFFF80, 32'h00000080, 32'h00008012,
                                   32'hFFFF8012, 32'h00003456, 32'h00000056};
        for (int i = 0; i < 6; i++)
            run_mem($sformatf("ld_sub%0d", i), addrs[i], f3s[i], 0, 0, 5'(i + 8),
                    32'h80123456, 0, bes[i], 0, exps[i], 2);
    endtask

    task automatic test_store();
        run_mem("sh_wait", 32'h102, 3'b001, 1, 32'h0000ABCD, 5'd4, 0, 3, 4'b1100, 32'hABCDABCD, 0, 4);
        run_mem("sb", 32'h101, 3'b000, 1, 32'h1234565A, 5'd6, 0, 0, 4'b0010, 32'h5A5A5A5A, 0, 1);
        run_mem("sw", 32'h200, 3'b010, 1, 32'hCAFEF00D, 5'd7, 0, 1, 4'b1111, 32'hCAFEF00D, 0, 2);
    endtask

    task automatic test_illegal();
        logic [31:0] addrs [5] = '{32'h101, 32'h100, 32'h101, 32'h100, 32'h104};
        logic [2:0]  f3s   [5] = '{3'b010, 3'b011, 3'b001, 3'b100, 3'b110};
        logic        sts   [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            push(5'd9, 0, 1'b0, 1'b0, 1'b1, addrs[i]);
            @(posedge clk); #1;
            in_valid = 1; in_rd = 5'd9; in_alu_result = addrs[i]; in_store_data = 32'h11223344;
            in_mem_read = !sts[i]; in_mem_write = sts[i]; in_funct3 = f3s[i]; in_wr_enable = 1;
            @(negedge clk);
            total++;
            if (stall !== 1'b0 || dmem_req !== 1'b0) begin
                bad++;
                $display("FAIL illegal%0d_nostall: got stall=%b req=%b, want 0 0", i, stall, dmem_req);
            end
            @(posedge clk); #1;
            idle_inputs();
            @(negedge clk);
            total++;
            if (dmem_req !== 1'b0) begin
                bad++;
                $display("FAIL illegal%0d_noreq: got req=%b, want 0", i, dmem_req);
            end
            drain($sformatf("illegal%0d", i));
        end
    endtask

    task automatic test_alu();
        push(5'd5, 32'h42, 1'b1, 1'b1, 1'b0, 0);
        @(posedge clk); #1;
        in_valid = 1; in_rd = 5'd5; in_alu_result = 32'h42; in_wr_enable = 1;
        @(negedge clk);
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL alu_stall: got %b, want 0", stall);
        end
        @(posedge clk); #1;
        idle_inputs();
        drain("alu");
    endtask

    task automatic test_back_to_back();
        logic        vs  [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic        wes [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        int          stall_seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (vs[i]) push(5'(i + 20), 32'h1000 + i, 1'b1, wes[i], 1'b0, 0);
            @(posedge clk); #1;
            in_valid = vs[i]; in_rd = 5'(i + 20); in_alu_result = 32'h1000 + i; in_wr_enable = wes[i];
            @(negedge clk);
            if (stall === 1'b1) stall_seen++;
        end
        @(posedge clk); #1;
        idle_inputs();
        total++;
        if (stall_seen != 0) begin
            bad++;
            $display("FAIL b2b_stall: got %0d stall cycles, want 0", stall_seen);
        end
        drain("b2b");
    endtask

    task automatic test_reset_in_wait();
        @(posedge clk); #1;
        in_valid = 1; in_rd = 5'd7; in_alu_result = 32'h100; in_mem_read = 1;
        in_funct3 = 3'b010; in_wr_enable = 1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (dmem_req !== 1'b1) begin
            bad++;
            $display("FAIL rstw_req: got req=%b, want 1", dmem_req);
        end
        dmem_gnt = 1;
        @(posedge clk); #1;
        dmem_gnt = 0;
        @(negedge clk);
        total++;
        if (stall !== 1'b1 || dmem_req !== 1'b0) begin
            bad++;
            $display("FAIL rstw_wait: got stall=%b req=%b, want 1 0", stall, dmem_req);
        end
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        idle_inputs();
        dmem_rvalid = 1; dmem_rdata = 32'h13579BDF;
        @(negedge clk);
        total++;
        if (stall !== 1'b0 || dmem_req !== 1'b0 || wb_valid !== 1'b0 || mem_exc !== 1'b0 ||
            wb_data !== 0 || dmem_be !== 0 || dmem_addr !== 0) begin
            bad++;
            $display("FAIL rstw_outputs: got stall=%b req=%b wbv=%b exc=%b wb_data=%h, want all 0",
                     stall, dmem_req, wb_valid, mem_exc, wb_data);
        end
        @(posedge clk); #1;
        dmem_rvalid = 0; dmem_rdata = 0;
        @(negedge clk);
        total++;
        if (wb_valid !== 1'b0 || dmem_req !== 1'b0) begin
            bad++;
            $display("FAIL rstw_ignored: got wbv=%b req=%b, want 0 0", wb_valid, dmem_req);
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_load_sub();
        test_store();
        test_illegal();
        test_alu();
        test_back_to_back();
        test_reset_in_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
